// File: rtl/timer_pulse_capture.sv
`default_nettype none
// ============================================================================
// Module   : timer_pulse_capture
// Counts unit_pulse ticks over one sig_in period (mode=0) or high time (mode=1).
// Optional capture_irq output is built when TIMER_CAPTURE_IRQ_EN is defined.
// Revision : 1.0
// ============================================================================
module timer_pulse_capture #(
    parameter int CAPTURE_WIDTH = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     unit_pulse,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     sig_in,
    output logic [CAPTURE_WIDTH-1:0] capture_value,
    output logic                     capture_valid,
    output logic                     overflow,
`ifdef TIMER_CAPTURE_IRQ_EN
    output logic                     capture_irq,
`endif
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [CAPTURE_WIDTH-1:0] c_cnt_max = '1;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     sig_dly_q, sig_dly_d;
    logic                     mode_q, mode_d;
    logic [CAPTURE_WIDTH-1:0] count_q, count_d;
    logic [CAPTURE_WIDTH-1:0] value_q, value_d;
    logic [CAPTURE_WIDTH-1:0] count_inc;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic                     sig_s, rise, fall, term_edge;

    assign sig_s     = sync_q[SYNC_STAGES-1];
    assign rise      = sig_s & ~sig_dly_q;
    assign fall      = ~sig_s & sig_dly_q;
    assign term_edge = mode_q ? fall : rise;
    assign count_inc = (count_q == c_cnt_max) ? count_q : count_q + 1'b1;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
        sig_dly_d = sig_s;
    end

    // enable dominates start, start dominates any edge in the same cycle
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        value_d = value_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = WAIT_EDGE;
            mode_d  = mode;
            count_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_EDGE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        count_d = '0;
                    end
                end
                MEASURE: begin
                    if (unit_pulse) begin
                        count_d = count_inc;
                        if (count_q == c_cnt_max) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (term_edge) begin
                        state_d = DONE;
                        value_d = count_d;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            sig_dly_q <= 1'b0;
            mode_q    <= 1'b0;
            count_q   <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            sig_dly_q <= sig_dly_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign capture_value = value_q;
    assign capture_valid = valid_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q == WAIT_EDGE) || (state_q == MEASURE);

`ifdef TIMER_CAPTURE_IRQ_EN
    logic irq_q, irq_d;

    // one-clk pulse aligned with the rise of either sticky flag
    assign irq_d = (valid_d & ~valid_q) | (ovf_d & ~ovf_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign capture_irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_pulse_capture.sv
`default_nettype none
// Bench for timer_pulse_capture: directed scenarios plus randomized stimulus,
// checked every cycle against a tick-counting behavioural model.
module tb_timer_pulse_capture;
    localparam int W    = 4;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         unit_pulse = 1'b0;
    logic         enable = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] capture_value;
    logic         capture_valid;
    logic         overflow;
    logic         busy;
`ifdef TIMER_CAPTURE_IRQ_EN
    logic         capture_irq;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int up_div = 1;
    int cyc    = 0;

    timer_pulse_capture #(
        .CAPTURE_WIDTH (W),
        .SYNC_STAGES   (S)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .unit_pulse    (unit_pulse),
        .enable        (enable),
        .start         (start),
        .mode          (mode),
        .sig_in        (sig_in),
        .capture_value (capture_value),
        .capture_valid (capture_valid),
        .overflow      (overflow),
`ifdef TIMER_CAPTURE_IRQ_EN
        .capture_irq   (capture_irq),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Time base: every up_div clks, or random when up_div is 0
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (up_div == 0) unit_pulse = ($urandom_range(0, 3) != 0);
        else             unit_pulse = ((cyc % up_div) == 0);
    end

    // Behavioural model: sig_in seen through an S+1 sample delay line,
    // true tick count kept unbounded and clipped only when reported.
    logic [S:0] hist    = '0;
    int         ph      = 0;
    logic       m_mode  = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_irq   = 1'b0;
    int         m_cnt   = 0;
    int         m_value = 0;
    logic       m_r, m_f;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            hist = '0; ph = 0; m_mode = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_irq = 1'b0; m_cnt = 0; m_value = 0;
        end else begin
            m_r   = hist[S-1] & ~hist[S];
            m_f   = ~hist[S-1] & hist[S];
            hist  = {hist[S-1:0], sig_in};
            m_irq = 1'b0;
            if (!enable) begin
                ph = 0;
            end else if (start) begin
                ph = 1; m_mode = mode; m_cnt = 0; m_valid = 1'b0; m_ovf = 1'b0;
            end else if (ph == 1) begin
                if (m_r) begin ph = 2; m_cnt = 0; end
            end else if (ph == 2) begin
                if (unit_pulse) m_cnt++;
                if (m_cnt > MAXV && !m_ovf) begin m_ovf = 1'b1; m_irq = 1'b1; end
                if (m_mode ? m_f : m_r) begin
                    m_value = (m_cnt > MAXV) ? MAXV : m_cnt;
                    m_valid = 1'b1; m_irq = 1'b1; ph = 3;
                end
            end
        end
    end

    initial forever begin
        logic exp_busy;
        logic bad;
        @(negedge clk);
        exp_busy = (ph == 1) || (ph == 2);
        bad = (int'(capture_value) != m_value) || (capture_valid !== m_valid) ||
              (overflow !== m_ovf) || (busy !== exp_busy);
`ifdef TIMER_CAPTURE_IRQ_EN
        if (capture_irq !== m_irq) bad = 1'b1;
`endif
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t value=%0d/%0d valid=%b/%b ovf=%b/%b busy=%b/%b (actual/required)",
                     $time, capture_value, m_value, capture_valid, m_valid,
                     overflow, m_ovf, busy, exp_busy);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic m);
        start = 1'b1; mode = m;
        tick();
        start = 1'b0;
    endtask

    task automatic drive_sig(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) tick();
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (capture_valid !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check("valid_timeout", int'(capture_valid === 1'b1), 1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_value", int'(capture_value), 0);
        check("rst_valid", int'(capture_valid), 0);
        check("rst_ovf",   int'(overflow), 0);
        check("rst_busy",  int'(busy), 0);
        reset_n = 1'b1; enable = 1'b1;
        tick();

        // Period: tick every 4 clks, 40-clk period
        up_div = 4;
        do_start(1'b0);
        drive_sig(1'b1, 20); drive_sig(1'b0, 20); sig_in = 1'b1;
        wait_valid(10);
        check("period_value", int'(capture_value), 10);
        check("period_ovf",   int'(overflow), 0);

        // High time: tick every clk, 12 clks high
        up_div = 1;
        drive_sig(1'b0, 5);
        do_start(1'b1);
        drive_sig(1'b1, 12); sig_in = 1'b0;
        wait_valid(10);
        check("high_value", int'(capture_value), 12);
        check("high_ovf",   int'(overflow), 0);

        // Saturation: 30 ticks into a 4-bit counter
        drive_sig(1'b0, 5);
        do_start(1'b0);
        drive_sig(1'b1, 15); drive_sig(1'b0, 15); sig_in = 1'b1;
        wait_valid(10);
        check("sat_value", int'(capture_value), 15);
        check("sat_ovf",   int'(overflow), 1);

        // Restart mid-measurement
        do_start(1'b0);
        drive_sig(1'b0, 5); drive_sig(1'b1, 8);
        do_start(1'b0);
        check("restart_valid", int'(capture_valid), 0);
        check("restart_value", int'(capture_value), 15);
        check("restart_busy",  int'(busy), 1);
        drive_sig(1'b0, 5); drive_sig(1'b1, 5); drive_sig(1'b0, 5); sig_in = 1'b1;
        wait_valid(10);
        check("restart_new_value", int'(capture_value), 10);
        check("restart_new_ovf",   int'(overflow), 0);

        // Abort via enable
        drive_sig(1'b0, 5);
        do_start(1'b0);
        drive_sig(1'b1, 8);
        check("abort_busy_pre", int'(busy), 1);
        enable = 1'b0;
        tick();
        check("abort_busy", int'(busy), 0);
        enable = 1'b1;
        drive_sig(1'b0, 5); drive_sig(1'b1, 5); drive_sig(1'b0, 5); drive_sig(1'b1, 5);
        check("abort_valid", int'(capture_valid), 0);
        check("abort_value", int'(capture_value), 10);

        // Reset mid-measurement after a capture of 7
        drive_sig(1'b0, 5);
        do_start(1'b1);
        drive_sig(1'b1, 7); sig_in = 1'b0;
        wait_valid(10);
        check("seven_value", int'(capture_value), 7);
        drive_sig(1'b0, 3);
        do_start(1'b1);
        drive_sig(1'b1, 6);
        reset_n = 1'b0;
        #1;
        check("midrst_value", int'(capture_value), 0);
        check("midrst_valid", int'(capture_valid), 0);
        check("midrst_ovf",   int'(overflow), 0);
        check("midrst_busy",  int'(busy), 0);
        tick(); tick();
        reset_n = 1'b1;
        drive_sig(1'b0, 5); drive_sig(1'b1, 5); drive_sig(1'b0, 5);
        check("postrst_valid", int'(capture_valid), 0);
        check("postrst_busy",  int'(busy), 0);

        // Randomized stimulus, checked by the per-cycle compare
        up_div = 0;
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 49) != 0);
            start   = ($urandom_range(0, 39) == 0);
            mode    = ($urandom_range(0, 1) == 1);
            reset_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 7) == 0) sig_in = ~sig_in;
            tick();
        end
        reset_n = 1'b1; start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/timer_pulse_capture.md
TIMER_PULSE_CAPTURE -- requirements
Module: timer_pulse_capture

Interface
REQ-001 SHALL have parameter CAPTURE_WIDTH, default 16: width of the tick counter and the captured result.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal values 2..4: number of flops in the sig_in synchronizer.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port unit_pulse  input  1  one-clk time-base tick from the timer unit-pulse generator.
REQ-006 SHALL have port enable  input  1  block enable; when low, the FSM is forced to IDLE.
REQ-007 SHALL have port start  input  1  one-clk arm strobe.
REQ-008 SHALL have port mode  input  1  0 = period (rise to next rise), 1 = high time (rise to fall); sampled on start.
REQ-009 SHALL have port sig_in  input  1  asynchronous signal under measurement.
REQ-010 SHALL have port capture_value  output  CAPTURE_WIDTH  number of unit_pulse ticks counted during the last measurement.
REQ-011 SHALL have port capture_valid  output  1  sticky flag: a result is available.
REQ-012 SHALL have port overflow  output  1  sticky flag: the counter saturated during the last measurement.
REQ-013 SHALL have port busy  output  1  high in states WAIT_EDGE and MEASURE.

Function
REQ-014 SHALL pass sig_in through SYNC_STAGES flops and then one delay flop, giving rise = s & ~s_d and fall = ~s & s_d.
- An edge on sig_in is therefore detected internally SYNC_STAGES+1 clks after it occurs.
REQ-015 SHALL implement a four-state FSM: IDLE, WAIT_EDGE, MEASURE, DONE.
REQ-016 SHALL move IDLE -> WAIT_EDGE on start while enable=1.
- On this transition it latches mode, clears the counter, clears capture_valid and clears overflow.
REQ-017 SHALL move WAIT_EDGE -> MEASURE on rise; the counter is 0 on entry to MEASURE.
REQ-018 SHALL, in MEASURE, add 1 to the counter on each unit_pulse.
REQ-019 SHALL leave MEASURE for DONE on the terminating edge: rise when latched mode=0, fall when latched mode=1.
- The cycle after the edge: capture_value equals the counter including any unit_pulse on the edge cycle, and capture_valid=1.
REQ-020 SHALL saturate the counter at all-ones and set overflow=1; the measurement still ends on the terminating edge.
REQ-021 SHALL hold capture_value, capture_valid and overflow in DONE and in IDLE until the next accepted start.
REQ-022 SHALL treat a start in WAIT_EDGE, MEASURE or DONE as a restart per REQ-016.
- A restart does not update capture_value.
REQ-023 SHALL, when enable=0, go to IDLE within 1 clk, discard any measurement in progress, keep the last results, and ignore start.
REQ-024 SHALL, when start and the terminating edge occur in the same cycle, give start priority: restart, no capture.
REQ-025 SHALL ignore a rise in MEASURE when mode=1, and a fall in WAIT_EDGE.
REQ-026 SHALL ignore unit_pulse in every state other than MEASURE.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force: FSM=IDLE, counter=0, capture_value=0, capture_valid=0, overflow=0, busy=0.
- Synchronizer flops are forced to 0 and latched mode to 0.
REQ-028 SHALL, when reset is asserted mid-measurement, discard the measurement and produce no capture after release.

Configuration
REQ-029 SHALL, when macro TIMER_CAPTURE_IRQ_EN is defined, add output capture_irq (1 bit).
- capture_irq is a one-clk pulse in the same cycle capture_valid rises.
- An overflow during a measurement also asserts capture_irq for one clk, in the cycle overflow rises.
- Reset value of capture_irq is 0.
REQ-030 SHALL, when TIMER_CAPTURE_IRQ_EN is undefined, omit capture_irq and its logic; all other behaviour is identical.

Verification
REQ-031 Period: unit_pulse every 4 clks, mode=0, sig_in period 40 clks -> capture_value=10, capture_valid=1, overflow=0.
REQ-032 High time: unit_pulse every clk, mode=1, sig_in high for 12 clks -> capture_value=12 (±0 with edges aligned to clk).
REQ-033 Saturation: CAPTURE_WIDTH=4, unit_pulse every clk, mode=0, period 30 clks -> capture_value=15, overflow=1; with TIMER_CAPTURE_IRQ_EN, capture_irq pulses twice.
REQ-034 Restart: start reissued mid-MEASURE -> counter restarts, previous capture_value unchanged, capture_valid=0 until the new result.
REQ-035 Abort: enable dropped in MEASURE -> busy=0 within 1 clk, state IDLE, no capture.
REQ-036 Reset mid-MEASURE with capture_value=7 -> all outputs 0 immediately; no capture after release.
